pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing and hazard controller for the 5-stage core (IF, ID, EX, M, WB). It tracks pending register writes in EX, M and WB in a shadow scoreboard and stalls IF/ID on read-after-write hazards, injecting bubbles into ID/EX. It also owns the run/halt state machine that starts the pipeline and drains it before a halt. It sits beside the ID stage and drives the PC enable, the IF/ID enable and the ID/EX bubble control.

---
 rtl/pipe_hazard_ctrl_if.sv | 55 +++++
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Bundle between the ID stage / pipeline front end and the hazard controller.
//
// Signals (direction given from the controller's point of view):
//   start, halt_req          in   run/halt requests
//   id_valid                 in   ID holds a real instruction
//   id_rs1, id_rs2           in   ID source register addresses
//   id_use_rs1, id_use_rs2   in   the instruction reads the corresponding source
//   id_wreg_en, id_wreg      in   destination register write enable / address
//   pc_en                    out  PC may advance
//   ifid_en                  out  IF/ID register may load
//   idex_bubble              out  ID/EX loads a NOP
//   stall                    out  hazard stall active this cycle
//   state                    out  0 IDLE, 1 RUN, 2 DRAIN, 3 HALTED
//   halted                   out  state is HALTED
//   stall_cnt                out  saturating count of hazard-stall cycles
//
// Modports: master = pipeline side driving requests and ID fields,
//           slave  = the hazard controller.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 3
);
    logic              start;
    logic              halt_req;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_wreg_en;
    logic [REG_AW-1:0] id_wreg;

    logic              pc_en;
    logic              ifid_en;
    logic              idex_bubble;
    logic              stall;
    logic [1:0]        state;
    logic              halted;
    logic [15:0]       stall_cnt;

    modport master (
        output start, halt_req, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_wreg_en, id_wreg,
        input  pc_en, ifid_en, idex_bubble, stall, state, halted, stall_cnt
    );

    modport slave (
        input  start, halt_req, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_wreg_en, id_wreg,
        output pc_en, ifid_en, idex_bubble, stall, state, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline sequencing and RAW-hazard controller for a 5-stage core. A shadow
// scoreboard mirrors the destination registers of the instructions in EX, M
// and WB; an ID instruction whose used sources match a pending write is held
// in IF/ID while bubbles are injected into ID/EX. A run/halt FSM starts the
// pipeline and drains it (DEPTH cycles of bubbles) before halting.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of pipe_hazard_ctrl_if (requests, ID fields, controls)
//
// Parameters:
//   REG_AW     register address width; must match the interface's REG_AW
//   DEPTH      write-pending stages after ID (sb[0]=EX ... sb[DEPTH-1]=WB)
//   WB_BYPASS  1: write-through register file, WB entry excluded from compare
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW    = 3,
    parameter int unsigned DEPTH     = 3,
    parameter bit          WB_BYPASS = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    bus
);

    // Number of scoreboard entries that take part in the hazard compare.
    localparam int unsigned CmpDepth = WB_BYPASS ? DEPTH - 1 : DEPTH;
    // Drain counter only has to hold DEPTH-1.
    localparam int unsigned CntW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StDrain  = 2'd2,
        StHalted = 2'd3
    } state_e;

    state_e            state_q;
    logic              halted_q;
    logic [CntW-1:0]   drain_cnt_q;
    logic [15:0]       stall_cnt_q;

    // Scoreboard: one {wen, waddr} entry per write-pending stage.
    logic [DEPTH-1:0]  sb_wen_q;
    logic [REG_AW-1:0] sb_waddr_q [DEPTH];

    logic run;
    logic hit_rs1;
    logic hit_rs2;
    logic hazard;
    logic issue;
    logic stall;
    logic shift_en;

    // -------------------------------------------------------------------------
    // Hazard detection. Register 0 is treated like any other register.
    // -------------------------------------------------------------------------
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        for (int k = 0; k < int'(CmpDepth); k++) begin
            if (sb_wen_q[k] && (sb_waddr_q[k] == bus.id_rs1)) begin
                hit_rs1 = 1'b1;
            end
            if (sb_wen_q[k] && (sb_waddr_q[k] == bus.id_rs2)) begin
                hit_rs2 = 1'b1;
            end
        end
    end

    assign run      = (state_q == StRun);
    assign hazard   = run && bus.id_valid &&
                      ((bus.id_use_rs1 && hit_rs1) || (bus.id_use_rs2 && hit_rs2));
    // halt_req wins over both issue and hazard: the front end freezes and the
    // stalled cycle is not counted.
    assign issue    = run && bus.id_valid && !hazard && !bus.halt_req;
    assign stall    = hazard && !bus.halt_req;
    assign shift_en = (state_q == StRun) || (state_q == StDrain);

    // -------------------------------------------------------------------------
    // Outputs. Front end advances only in RUN with neither hazard nor halt;
    // everything that does not issue becomes a bubble in ID/EX.
    // -------------------------------------------------------------------------
    assign bus.pc_en       = run && !hazard && !bus.halt_req;
    assign bus.ifid_en     = run && !hazard && !bus.halt_req;
    assign bus.idex_bubble = !issue;
    assign bus.stall       = stall;
    assign bus.state       = state_q;
    assign bus.halted      = halted_q;
    assign bus.stall_cnt   = stall_cnt_q;

    // -------------------------------------------------------------------------
    // Run/halt FSM, drain counter, stall counter and scoreboard.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            halted_q    <= 1'b0;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
            sb_wen_q    <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                sb_waddr_q[k] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q     <= StRun;
                        stall_cnt_q <= '0;
                    end
                end
                StRun: begin
                    if (bus.halt_req) begin
                        state_q     <= StDrain;
                        drain_cnt_q <= CntW'(DEPTH - 1);
                    end
                end
                StDrain: begin
                    // DEPTH drain cycles flush every pending write out of WB.
                    if (drain_cnt_q == '0) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 1'b1;
                    end
                end
                StHalted: begin
                    // Resume keeps the frozen IF/ID contents and the stall count.
                    if (bus.start) begin
                        state_q  <= StRun;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    halted_q <= 1'b0;
                end
            endcase

            // stall only occurs in RUN, so this never collides with the clear
            // on start in IDLE.
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end

            if (shift_en) begin
                for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                    sb_wen_q[k]   <= sb_wen_q[k-1];
                    sb_waddr_q[k] <= sb_waddr_q[k-1];
                end
                sb_wen_q[0]   <= issue ? bus.id_wreg_en : 1'b0;
                sb_waddr_q[0] <= issue ? bus.id_wreg : '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl (DEPTH=3, WB_BYPASS=0). The stimulus
// process drives one cycle at a time and queues the expected outputs for that
// cycle; a monitor on the falling edge pops and compares.
// Expected vector layout: {pc_en, ifid_en, idex_bubble, stall, state, halted,
// stall_cnt}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.REG_AW(3)) bus ();

    pipe_hazard_ctrl #(
        .REG_AW    (3),
        .DEPTH     (3),
        .WB_BYPASS (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   failures;

    function automatic logic [22:0] ev(input logic pc, input logic ifid, input logic bub,
                                       input logic st, input logic [1:0] sta,
                                       input logic hl, input logic [15:0] cnt);
        return {pc, ifid, bub, st, sta, hl, cnt};
    endfunction

    // Monitor: compare whatever the DUT presents mid-cycle against the queue.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [22:0] act;
            e   = exp_q.pop_front();
            act = {bus.pc_en, bus.ifid_en, bus.idex_bubble, bus.stall, bus.state,
                   bus.halted, bus.stall_cnt};
            tests++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s: got pc=%b ifid=%b bub=%b stall=%b state=%0d halted=%b cnt=%0d, expected pc=%b ifid=%b bub=%b stall=%b state=%0d halted=%b cnt=%0d",
                         e.name, act[22], act[21], act[20], act[19], act[18:17], act[16],
                         act[15:0], e.v[22], e.v[21], e.v[20], e.v[19], e.v[18:17], e.v[16],
                         e.v[15:0]);
            end
        end
    end

    task automatic set_id(input logic v, input logic [2:0] rs1, input logic u1,
                          input logic [2:0] rs2, input logic u2,
                          input logic we, input logic [2:0] wd);
        bus.id_valid   = v;
        bus.id_rs1     = rs1;
        bus.id_use_rs1 = u1;
        bus.id_rs2     = rs2;
        bus.id_use_rs2 = u2;
        bus.id_wreg_en = we;
        bus.id_wreg    = wd;
    endtask

    // Drive one cycle's requests, queue its expected outputs, advance a cycle.
    task automatic tick(input string name, input logic r, input logic s, input logic h,
                        input logic [22:0] e);
        exp_t x;
        rst          = r;
        bus.start    = s;
        bus.halt_req = h;
        x.v          = e;
        x.name       = name;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    localparam logic [22:0] Idle0 = 23'h10_0000; // bubble=1, all else 0

    initial begin
        tests    = 0;
        failures = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.halt_req = 1'b0;
        set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #1;

        // Reset and idle hold; halt_req in IDLE is ignored.
        tick("reset", 1'b1, 1'b0, 1'b0, Idle0);
        for (int i = 0; i < 5; i++) tick("idle_hold", 1'b0, 1'b0, (i == 2), Idle0);
        tick("start_idle", 1'b0, 1'b1, 1'b0, Idle0);

        // Producer then immediate consumer: 3 stall cycles.
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2);
        tick("i0_issue", 1'b0, 1'b0, 1'b0, ev(1, 1, 0, 0, 2'd1, 0, 16'd0));
        set_id(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3);
        tick("raw_stall1", 1'b0, 1'b0, 1'b0, ev(0, 0, 1, 1, 2'd1, 0, 16'd0));
        tick("raw_stall2", 1'b0, 1'b0, 1'b0, ev(0, 0, 1, 1, 2'd1, 0, 16'd1));
        tick("raw_stall3", 1'b0, 1'b0, 1'b0, ev(0, 0, 1, 1, 2'd1, 0, 16'd2));
        tick("raw_issue", 1'b0, 1'b0, 1'b0, ev(1, 1, 0, 0, 2'd1, 0, 16'd3));

        // Non-writing producer, consumer of r0: no stall.
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        tick("wen0_issue", 1'b0, 1'b0, 1'b0, ev(1, 1, 0, 0, 2'd1, 0, 16'd3));
        set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0);
        tick("rs0_nostall", 1'b0, 1'b0, 1'b0, ev(1, 1, 0, 0, 2'd1, 0, 16'd3));

        // Five independent instructions.
        for (int d = 1; d <= 5; d++) begin
            set_id(1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 1'b1, 3'(d));
            tick("indep", 1'b0, 1'b0, 1'b0, ev(1, 1, 0, 0, 2'd1, 0, 16'd3));
        end

        // Hazard on r5, then halt while the hazard persists.
        set_id(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1);
        tick("hz_before_halt", 1'b0, 1'b0, 1'b0, ev(0, 0, 1, 1, 2'd1, 0, 16'd3));
        tick("halt_over_hz", 1'b0, 1'b0, 1'b1, ev(0, 0, 1, 0, 2'd1, 0, 16'd4));
        tick("drain1", 1'b0, 1'b1, 1'b0, ev(0, 0, 1, 0, 2'd2, 0, 16'd4));
        tick("drain2", 1'b0, 1'b0, 1'b1, ev(0, 0, 1, 0, 2'd2, 0, 16'd4));
        tick("drain3", 1'b0, 1'b0, 1'b0, ev(0, 0, 1, 0, 2'd2, 0, 16'd4));
        tick("halted", 1'b0, 1'b0, 1'b1, ev(0, 0, 1, 0, 2'd3, 1, 16'd4));
        tick("halted_start", 1'b0, 1'b1, 1'b0, ev(0, 0, 1, 0, 2'd3, 1, 16'd4));
        // Frozen instruction re-evaluates against a drained scoreboard.
        tick("resume_issue", 1'b0, 1'b0, 1'b0, ev(1, 1, 0, 0, 2'd1, 0, 16'd4));

        // Build a pending write to r1, then reset in the middle of DRAIN.
        set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0);
        tick("hz2", 1'b0, 1'b0, 1'b0, ev(0, 0, 1, 1, 2'd1, 0, 16'd4));
        set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        tick("halt2", 1'b0, 1'b0, 1'b1, ev(0, 0, 1, 0, 2'd1, 0, 16'd5));
        tick("drain_rst", 1'b1, 1'b0, 1'b0, ev(0, 0, 1, 0, 2'd2, 0, 16'd5));
        tick("after_rst", 1'b0, 1'b0, 1'b0, Idle0);
        tick("start2", 1'b0, 1'b1, 1'b0, Idle0);
        set_id(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 1'b1, 3'd2);
        tick("first_nostall", 1'b0, 1'b0, 1'b0, ev(1, 1, 0, 0, 2'd1, 0, 16'd0));
        set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        tick("run_novalid", 1'b0, 1'b0, 1'b0, ev(1, 1, 1, 0, 2'd1, 0, 16'd0));

        // Bounded wait for the monitor to consume the last entries.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
